// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: state encodings, ASCII command defaults, event bundle.
// Also used by the UART TX echo and the FND mux.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    ST_STOP  = 3'd0,
    ST_RUN   = 3'd1,
    ST_CLEAR = 3'd2,
    ST_LAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] CMD_RUN_DEF   = 8'h52;  // 'R'
  localparam logic [7:0] CMD_STOP_DEF  = 8'h53;  // 'S'
  localparam logic [7:0] CMD_CLEAR_DEF = 8'h43;  // 'C'
  localparam logic [7:0] CMD_LAP_DEF   = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_MODE_DEF  = 8'h4D;  // 'M'

  // Button bit positions into the edge detector
  localparam int BTN_RUNSTOP = 0;
  localparam int BTN_CLEAR   = 1;
  localparam int BTN_LAP     = 2;

  typedef struct packed {
    logic start;    // run request, only meaningful from STOP
    logic halt;     // stop request, only meaningful from RUN/LAP
    logic btn_rs;   // raw runstop button edge (DONE reacts to this only)
    logic clear;
    logic lap;
    logic mode;
  } ev_t;

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_ext_edge_det.sv
// Rising-edge detector: one-cycle pulse on the cycle a level input first goes high.
// History is registered; the pulse itself is combinational so events keep single-edge latency.
module edge_det #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] level,
  output logic [W-1:0] rise
);

  logic [W-1:0] hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= '0;
    end else begin
      hist <= level;
    end
  end

  assign rise = level & ~hist;

endmodule

// File: rtl/stopwatch_ctrl_ext.sv
// Stopwatch/timer control unit: Moore FSM driven by button edges and UART command bytes.
// Produces run/clear/lap-hold/done for the datapath; outputs change one edge after an event.
module stopwatch_ctrl_ext
  import stopwatch_pkg::*;
#(
  parameter int                DATA_W       = 8,
  parameter int                CLEAR_CYCLES = 4,
  parameter logic [DATA_W-1:0] CMD_RUN      = DATA_W'(CMD_RUN_DEF),
  parameter logic [DATA_W-1:0] CMD_STOP     = DATA_W'(CMD_STOP_DEF),
  parameter logic [DATA_W-1:0] CMD_CLEAR    = DATA_W'(CMD_CLEAR_DEF),
  parameter logic [DATA_W-1:0] CMD_LAP      = DATA_W'(CMD_LAP_DEF),
  parameter logic [DATA_W-1:0] CMD_MODE     = DATA_W'(CMD_MODE_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_btn_runstop,
  input  logic              i_btn_clear,
  input  logic              i_btn_lap,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_zero,
  output logic              o_run,
  output logic              o_clear,
  output logic              o_lap_hold,
  output logic              o_mode_down,
  output logic              o_done,
  output logic [2:0]        o_state
);

  localparam int CW = cnt_w(CLEAR_CYCLES);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_CYCLES - 1);

  state_t        state, state_next;
  logic [CW-1:0] clr_cnt;
  logic          mode_down;
  logic          mode_toggle;
  logic [2:0]    btn_rise;
  ev_t           ev;

  edge_det #(.W(3)) u_edge_det (
    .clk   (clk),
    .rst   (rst),
    .level ({i_btn_lap, i_btn_clear, i_btn_runstop}),
    .rise  (btn_rise)
  );

  // Event decode: RUN/STOP bytes stay separate so each is honoured only in its own direction
  always_comb begin
    ev        = '0;
    ev.btn_rs = btn_rise[BTN_RUNSTOP];
    ev.start  = btn_rise[BTN_RUNSTOP] | (i_rx_valid & (i_rx_data == CMD_RUN));
    ev.halt   = btn_rise[BTN_RUNSTOP] | (i_rx_valid & (i_rx_data == CMD_STOP));
    ev.clear  = btn_rise[BTN_CLEAR]   | (i_rx_valid & (i_rx_data == CMD_CLEAR));
    ev.lap    = btn_rise[BTN_LAP]     | (i_rx_valid & (i_rx_data == CMD_LAP));
    ev.mode   = i_rx_valid & (i_rx_data == CMD_MODE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_STOP;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    mode_toggle = 1'b0;
    case (state)
      ST_STOP: begin
        // A down-counting timer already at zero must not start
        if (ev.start && !(mode_down && i_zero)) begin
          state_next = ST_RUN;
        end else if (ev.clear) begin
          state_next = ST_CLEAR;
        end else if (ev.mode) begin
          mode_toggle = 1'b1;
        end
      end
      ST_RUN: begin
        if (mode_down && i_zero) begin
          state_next = ST_DONE;
        end else if (ev.halt) begin
          state_next = ST_STOP;
        end else if (ev.lap) begin
          state_next = ST_LAP;
        end
      end
      ST_LAP: begin
        if (mode_down && i_zero) begin
          state_next = ST_DONE;
        end else if (ev.halt) begin
          state_next = ST_STOP;
        end else if (ev.lap) begin
          state_next = ST_RUN;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt == CLR_LAST) begin
          state_next = ST_STOP;
        end
      end
      ST_DONE: begin
        if (ev.btn_rs || ev.clear) begin
          state_next = ST_CLEAR;
        end
      end
      default: begin
        state_next = ST_STOP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt <= '0;
    end else if (state != ST_CLEAR) begin
      clr_cnt <= '0;
    end else begin
      clr_cnt <= clr_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_down <= 1'b0;
    end else if (mode_toggle) begin
      mode_down <= ~mode_down;
    end
  end

  assign o_run       = (state == ST_RUN) || (state == ST_LAP);
  assign o_clear     = (state == ST_CLEAR);
  assign o_lap_hold  = (state == ST_LAP);
  assign o_done      = (state == ST_DONE);
  assign o_mode_down = mode_down;
  assign o_state     = state;

endmodule

// File: tb/tb_stopwatch_ctrl_ext.sv
// Scoreboard bench for stopwatch_ctrl_ext: driver pushes model predictions, monitor pops and compares.
module tb_stopwatch_ctrl_ext;

  localparam int CLR_N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_rs, btn_clr, btn_lap;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       zero;
  logic       o_run, o_clear, o_lap_hold, o_mode_down, o_done;
  logic [2:0] o_state;

  int checks = 0;
  int passes = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];
  string      phase;

  // Reference model: named modes plus a remaining-clear-cycles counter
  int   m_st;     // 0 stop, 1 run, 2 clear, 3 lap, 4 done
  bit   m_down;
  int   m_left;
  bit   m_h_rs, m_h_clr, m_h_lap;

  always #5 clk = ~clk;

  stopwatch_ctrl_ext dut (
    .clk           (clk),
    .rst           (rst),
    .i_btn_runstop (btn_rs),
    .i_btn_clear   (btn_clr),
    .i_btn_lap     (btn_lap),
    .i_rx_data     (rx_data),
    .i_rx_valid    (rx_valid),
    .i_zero        (zero),
    .o_run         (o_run),
    .o_clear       (o_clear),
    .o_lap_hold    (o_lap_hold),
    .o_mode_down   (o_mode_down),
    .o_done        (o_done),
    .o_state       (o_state)
  );

  function automatic logic [7:0] model_outs();
    logic [7:0] v;
    v[7:5] = 3'(m_st);
    v[4]   = m_down;
    v[3]   = (m_st == 4);
    v[2]   = (m_st == 3);
    v[1]   = (m_st == 2);
    v[0]   = (m_st == 1) || (m_st == 3);
    return v;
  endfunction

  task automatic model_step();
    bit   e_rs, e_clr, e_lap;
    int   cmd;
    if (rst) begin
      m_st = 0; m_down = 0; m_left = 0;
      m_h_rs = 0; m_h_clr = 0; m_h_lap = 0;
      return;
    end
    e_rs  = btn_rs  && !m_h_rs;
    e_clr = btn_clr && !m_h_clr;
    e_lap = btn_lap && !m_h_lap;
    m_h_rs = btn_rs; m_h_clr = btn_clr; m_h_lap = btn_lap;
    cmd = rx_valid ? int'(rx_data) : -1;
    case (m_st)
      0: begin
        if ((e_rs || cmd == "R") && !(m_down && zero)) m_st = 1;
        else if (e_clr || cmd == "C") begin m_st = 2; m_left = CLR_N; end
        else if (cmd == "M") m_down = !m_down;
      end
      1, 3: begin
        if (m_down && zero) m_st = 4;
        else if (e_rs || cmd == "S") m_st = 0;
        else if (e_lap || cmd == "L") m_st = (m_st == 1) ? 3 : 1;
      end
      2: begin
        m_left = m_left - 1;
        if (m_left == 0) m_st = 0;
      end
      default: begin
        if (e_rs || e_clr || cmd == "C") begin m_st = 2; m_left = CLR_N; end
      end
    endcase
  endtask

  task automatic step();
    model_step();
    exp_q.push_back(model_outs());
    tag_q.push_back(phase);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic rx(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic press_rs();
    btn_rs = 1'b1;
    step();
    btn_rs = 1'b0;
  endtask

  // Monitor: compares each post-edge output bundle against the oldest prediction
  initial begin
    logic [7:0] got, want;
    string      t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        got  = {o_state, o_mode_down, o_done, o_lap_hold, o_clear, o_run};
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got state=%0d mode=%b done=%b lap=%b clr=%b run=%b, want state=%0d mode=%b done=%b lap=%b clr=%b run=%b",
                      t, got[7:5], got[4], got[3], got[2], got[1], got[0],
                      want[7:5], want[4], want[3], want[2], want[1], want[0]);
      end
    end
  end

  initial begin
    logic [7:0] cmds [7];
    cmds[0] = "R"; cmds[1] = "S"; cmds[2] = "C"; cmds[3] = "L";
    cmds[4] = "M"; cmds[5] = "X"; cmds[6] = 8'h00;
    rst = 1'b1; btn_rs = 0; btn_clr = 0; btn_lap = 0;
    rx_data = 8'h00; rx_valid = 0; zero = 0;

    phase = "reset";
    idle(2);
    rst = 1'b0;
    idle(3);

    phase = "btn_hold_runstop";
    btn_rs = 1'b1; idle(10); btn_rs = 1'b0; idle(2);
    press_rs(); idle(2);

    phase = "uart_lap_stop";
    press_rs(); idle(1);
    rx("L"); idle(1); rx("L"); rx("S"); rx("S"); idle(2);

    phase = "clear_pulse";
    btn_clr = 1'b1; step(); btn_clr = 1'b0;
    btn_rs = 1'b1; idle(3); btn_rs = 1'b0; idle(4);

    phase = "rst_mid_clear";
    rx("C"); idle(1);
    rst = 1'b1; step(); rst = 1'b0; idle(2);

    phase = "timer_done";
    rx("M"); press_rs(); idle(2);
    zero = 1'b1; idle(2);
    rx("R"); idle(1);
    press_rs(); zero = 1'b0; idle(6);

    phase = "down_zero_no_start";
    zero = 1'b1; press_rs(); idle(1); zero = 1'b0;

    phase = "simultaneous_and_unknown";
    rx("M"); idle(1);
    btn_rs = 1'b1; rx("C"); btn_rs = 1'b0; idle(2);
    rx("X"); rx("S"); idle(1);
    rx_data = "R"; idle(2); rx_data = 8'h00;

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 5) == 0) btn_rs  = ~btn_rs;
      if ($urandom_range(0, 9) == 0) btn_clr = ~btn_clr;
      if ($urandom_range(0, 6) == 0) btn_lap = ~btn_lap;
      rx_valid = ($urandom_range(0, 3) == 0);
      rx_data  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : cmds[$urandom_range(0, 6)];
      zero     = ($urandom_range(0, 11) == 0);
      step();
    end
    rst = 1'b0; rx_valid = 1'b0; btn_rs = 0; btn_clr = 0; btn_lap = 0; zero = 0;
    phase = "drain";
    idle(2);
    repeat (3) @(negedge clk);

    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: %0d predictions left, want 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
